button_bounce_emulator: RTL and testbench
=========================================

// Module: button_bounce_emulator
// PURPOSE
//  Drives a synthetic mechanical-button waveform: on command, o_button moves to a target level
//  via a burst of pseudo-random-width glitches, then holds clean. It is the stimulus end of the
//  button path (synchroniser -> debouncer -> press counter / LED pulse). Used on-board for
//  self-test and in benches so the debouncer sees realistic, repeatable bounce.
// PARAMETERS
//  NUM_BOUNCES   2         full glitch pairs before the final edge; toggles = 2*NUM_BOUNCES+1
//  MIN_GAP       4         minimum cycles between toggles (>=1)
//  GAP_BITS      2         random gap extension width; gap = MIN_GAP + lfsr[GAP_BITS-1:0]
//  SETTLE_CYCLES 10        clean-hold cycles after the final toggle, before o_done
//  LFSR_SEED     16'hACE1  LFSR reset value; 0 is replaced by 16'hACE1
// PORTS
//  i_clk      in   1  system clock
//  i_reset    in   1  asynchronous, active-high reset
//  i_start    in   1  1-cycle request: begin a transition to i_level
//  i_level    in   1  target button level, sampled with i_start (1 = pressed)
//  o_button   out  1  emulated raw button; feeds the synchroniser input
//  o_busy     out  1  high from the cycle after an accepted i_start until o_done
//  o_done     out  1  1-cycle pulse: transition complete, o_button == target
// BEHAVIOUR
//  - Reset (async, i_reset=1): o_button=0, o_busy=0, o_done=0, state=IDLE, lfsr=LFSR_SEED,
//    counters=0. Reset mid-burst aborts immediately; o_button drops to 0 without further glitches.
//  - FSM: IDLE -> BOUNCE -> SETTLE -> DONE -> IDLE.
//  - IDLE: i_start=1 at edge k latches target=i_level. At k+1 o_busy=1.
//      target != o_button: enter BOUNCE; toggle count = 2*NUM_BOUNCES+1; gap counter = gap(lfsr).
//      target == o_button: enter SETTLE directly; no toggles. SETTLE counter = SETTLE_CYCLES.
//  - BOUNCE: gap counter decrements each cycle. When it reaches 1, the next edge toggles o_button,
//    advances the LFSR by one step, decrements the toggle count, and reloads gap(new lfsr).
//    Consecutive toggles are therefore exactly gap cycles apart, with gap in
//    [MIN_GAP, MIN_GAP+2^GAP_BITS-1]. After the last toggle (o_button==target): SETTLE.
//  - SETTLE: o_button held. After SETTLE_CYCLES cycles: DONE.
//  - DONE: o_done=1 for exactly one cycle, o_busy=0 in the same cycle. Then IDLE.
//  - i_start in any state other than IDLE (including DONE) is ignored; it is not queued.
//  - LFSR: 16-bit Galois, taps 16'hB400, shift right. It advances only on toggles, so the waveform
//    is a deterministic function of seed and command history. It never reaches 0.
//  - Widths: gap counter $clog2(MIN_GAP+2^GAP_BITS)+1; toggle count $clog2(2*NUM_BOUNCES+2);
//    settle counter $clog2(SETTLE_CYCLES+1). No wrap-around is possible within these widths.
//  - Registered outputs only; o_button has no combinational path from the inputs.
// STRUCTURE
//  - Shared package/include bounce_pkg: FSM state encodings (IDLE, BOUNCE, SETTLE, DONE),
//    LFSR_TAPS=16'hB400, DEFAULT_SEED=16'hACE1.
//  - Sub-module lfsr16 (i_clk, i_reset, i_step, i_seed, o_state). The FSM and counters stay
//    in this module.
// TESTING (defaults: NUM_BOUNCES=2, MIN_GAP=4, GAP_BITS=2, SETTLE_CYCLES=10, seed 16'hACE1)
//  1 Assert i_reset mid-clock -> o_button=0, o_busy=0, o_done=0 before the next edge.
//  2 i_start=1, i_level=1 from idle -> o_busy=1 next cycle; exactly 5 o_button toggles, each gap
//    in 4..7; final o_button=1; o_done pulses once, 10 cycles after the last toggle.
//  3 With o_button=1, i_start with i_level=1 -> zero toggles; o_done 11 cycles after i_start.
//  4 Second i_start during BOUNCE and another in the DONE cycle -> both ignored; toggle count
//    stays 5; single o_done.
//  5 i_reset asserted after toggle 3 -> o_button=0 at once, no further toggles; a fresh press
//    then reproduces scenario 2's gap sequence bit-for-bit.
//  6 Loop to debouncer + press counter: 4 press/release pairs -> counter LEDs = 8'd4.

Source files
------------

// File: rtl/bounce_pkg.sv
// Shared definitions for the button bounce emulator: FSM state codes,
// LFSR constants and the single-step LFSR update.
package bounce_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BOUNCE = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One step of a 16-bit right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances only when stepped. A zero seed would
// lock the register at zero, so it is replaced by the default seed.
module lfsr16
    import bounce_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_step,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] seed_eff;
    logic [15:0] state_d;
    logic [15:0] state_q;

    // Pick the reset value and compute the next state.
    always_comb begin
        seed_eff = (i_seed == 16'h0000) ? DEFAULT_SEED : i_seed;
        state_d  = i_step ? lfsr_step(state_q) : state_q;
    end

    // State register, reloaded with the seed on reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= seed_eff;
        else         state_q <= state_d;
    end

    assign o_state = state_q;

endmodule

// File: rtl/button_bounce_emulator.sv
// Synthetic mechanical button: on command, walks o_button to the requested
// level through a burst of pseudo-random-width glitches, holds it clean for
// a settle period, then pulses o_done. All outputs are registered.
module button_bounce_emulator
    import bounce_pkg::*;
#(
    parameter int          NUM_BOUNCES   = 2,
    parameter int          MIN_GAP       = 4,
    parameter int          GAP_BITS      = 2,
    parameter int          SETTLE_CYCLES = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_level,
    output logic o_button,
    output logic o_busy,
    output logic o_done
);

    localparam int TOGGLES = 2 * NUM_BOUNCES + 1;
    localparam int GAP_W   = $clog2(MIN_GAP + (1 << GAP_BITS)) + 1;
    localparam int TOG_W   = $clog2(2 * NUM_BOUNCES + 2);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

    logic [1:0]       state_d,  state_q;
    logic             target_d, target_q;
    logic             button_d, button_q;
    logic             busy_d,   busy_q;
    logic             done_d,   done_q;
    logic [GAP_W-1:0] gap_d,    gap_q;
    logic [TOG_W-1:0] tog_d,    tog_q;
    logic [SET_W-1:0] settle_d, settle_q;
    logic             lfsr_advance;
    logic [15:0]      lfsr_state;

    // Gap between toggles: a fixed floor plus a few random LFSR bits.
    function automatic logic [GAP_W-1:0] gap_of(input logic [15:0] s);
        return GAP_W'(MIN_GAP) + GAP_W'(s[GAP_BITS-1:0]);
    endfunction

    lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_step  (lfsr_advance),
        .i_seed  (LFSR_SEED),
        .o_state (lfsr_state)
    );

    // Next-state logic for the FSM, counters and output registers.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        button_d     = button_q;
        gap_d        = gap_q;
        tog_d        = tog_q;
        settle_d     = settle_q;
        lfsr_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    target_d = i_level;
                    if (i_level != button_q) begin
                        state_d = ST_BOUNCE;
                        tog_d   = TOG_W'(TOGGLES);
                        gap_d   = gap_of(lfsr_state);
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = SET_W'(SETTLE_CYCLES);
                    end
                end
            end
            ST_BOUNCE: begin
                if (gap_q <= GAP_W'(1)) begin
                    lfsr_advance = 1'b1;
                    tog_d        = tog_q - TOG_W'(1);
                    gap_d        = gap_of(lfsr_step(lfsr_state));
                    if (tog_q == TOG_W'(1)) begin
                        // Last toggle always lands exactly on the target.
                        button_d = target_q;
                        state_d  = ST_SETTLE;
                        settle_d = SET_W'(SETTLE_CYCLES);
                    end else begin
                        button_d = ~button_q;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_q <= SET_W'(1)) state_d  = ST_DONE;
                else                       settle_d = settle_q - SET_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_BOUNCE) || (state_d == ST_SETTLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any burst immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            target_q <= 1'b0;
            button_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gap_q    <= '0;
            tog_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            button_q <= button_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gap_q    <= gap_d;
            tog_q    <= tog_d;
            settle_q <= settle_d;
        end
    end

    assign o_button = button_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_button_bounce_emulator.sv
// Directed bench for button_bounce_emulator with default parameters.
// Expected toggle positions come from hand-stepping the LFSR from 16'hACE1.
module tb_button_bounce_emulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_start = 1'b0;
    logic i_level = 1'b0;
    logic o_button;
    logic o_busy;
    logic o_done;

    int errors = 0;
    int checks = 0;

    int   tog_cnt;
    int   tog_at [16];
    int   done_cnt;
    int   done_at;
    logic busy_at_done;

    // Expected toggle cycles for a press from seed ACE1 (gaps 5,4,4,4,6).
    int exp_seed_tog [5] = '{5, 9, 13, 17, 23};
    // Expected toggle cycles for the release starting from LFSR 0E27 (gaps 7,7,5,4,6).
    int exp_rel_tog  [5] = '{7, 14, 19, 23, 29};

    // Debouncer and press-counter model on the bench side.
    logic       db_last  = 1'b0;
    logic [3:0] db_cnt   = 4'd0;
    logic       db_out   = 1'b0;
    logic       db_out_d = 1'b0;
    logic       db_clr   = 1'b0;
    logic [7:0] leds     = 8'd0;

    button_bounce_emulator dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_start  (i_start),
        .i_level  (i_level),
        .o_button (o_button),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        db_last <= o_button;
        if (o_button != db_last) db_cnt <= 4'd0;
        else if (db_cnt != 4'd15) db_cnt <= db_cnt + 4'd1;
        if (db_cnt == 4'd8) db_out <= db_last;
        db_out_d <= db_out;
        if (db_clr) leds <= 8'd0;
        else if (db_out && !db_out_d) leds <= leds + 8'd1;
    end

    task automatic start(input logic lvl);
        @(negedge clk);
        i_start = 1'b1;
        i_level = lvl;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic watch(input int cycles, input int stop_tog, input int inj_n,
                         input logic inj_lvl, input logic inj_done);
        logic prev;
        prev = o_button;
        tog_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        busy_at_done = 1'b1;
        for (int n = 1; n <= cycles; n++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_button !== prev) begin
                if (tog_cnt < 16) tog_at[tog_cnt] = n;
                tog_cnt++;
                prev = o_button;
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_at = n;
                busy_at_done = o_busy;
            end
            if (n == inj_n || (inj_done && o_done === 1'b1)) begin
                i_start = 1'b1;
                i_level = inj_lvl;
            end
            if (stop_tog > 0 && tog_cnt >= stop_tog) break;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_button !== 1'b0) begin errors++; $display("FAIL reset_button got=%b want=0", o_button); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", o_done); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_press_bounce();
        start(1'b1);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL press_busy got=%b want=1", o_busy); end
        watch(45, 0, -1, 1'b0, 1'b0);
        checks++; if (tog_cnt !== 5) begin errors++; $display("FAIL press_toggles got=%0d want=5", tog_cnt); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tog_at[i] !== exp_seed_tog[i]) begin
                errors++; $display("FAIL press_tog%0d got=%0d want=%0d", i, tog_at[i], exp_seed_tog[i]);
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL press_done_cnt got=%0d want=1", done_cnt); end
        checks++; if (done_at !== 33) begin errors++; $display("FAIL press_done_at got=%0d want=33", done_at); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL press_busy_at_done got=%b want=0", busy_at_done); end
        checks++; if (o_button !== 1'b1) begin errors++; $display("FAIL press_final got=%b want=1", o_button); end
    endtask

    task automatic test_same_level();
        start(1'b1);
        watch(20, 0, -1, 1'b0, 1'b0);
        checks++; if (tog_cnt !== 0) begin errors++; $display("FAIL same_toggles got=%0d want=0", tog_cnt); end
        checks++; if (done_at !== 10) begin errors++; $display("FAIL same_done_at got=%0d want=10", done_at); end
        checks++; if (o_button !== 1'b1) begin errors++; $display("FAIL same_button got=%b want=1", o_button); end
    endtask

    task automatic test_ignore_start();
        start(1'b0);
        watch(55, 0, 10, 1'b1, 1'b1);
        checks++; if (tog_cnt !== 5) begin errors++; $display("FAIL ignore_toggles got=%0d want=5", tog_cnt); end
        checks++; if (tog_at[4] !== exp_rel_tog[4]) begin errors++; $display("FAIL ignore_last_tog got=%0d want=%0d", tog_at[4], exp_rel_tog[4]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_cnt got=%0d want=1", done_cnt); end
        checks++; if (done_at !== 39) begin errors++; $display("FAIL ignore_done_at got=%0d want=39", done_at); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got=%b want=0", o_busy); end
        checks++; if (o_button !== 1'b0) begin errors++; $display("FAIL ignore_button got=%b want=0", o_button); end
    endtask

    task automatic test_reset_mid_burst();
        start(1'b1);
        watch(40, 3, -1, 1'b0, 1'b0);
        checks++; if (tog_cnt !== 3) begin errors++; $display("FAIL abort_reach3 got=%0d want=3", tog_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (o_button !== 1'b0) begin errors++; $display("FAIL abort_button got=%b want=0", o_button); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", o_busy); end
        @(negedge clk);
        rst = 1'b0;
        watch(20, 0, -1, 1'b0, 1'b0);
        checks++; if (tog_cnt !== 0) begin errors++; $display("FAIL abort_quiet got=%0d want=0", tog_cnt); end
        start(1'b1);
        watch(45, 0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tog_at[i] !== exp_seed_tog[i]) begin
                errors++; $display("FAIL replay_tog%0d got=%0d want=%0d", i, tog_at[i], exp_seed_tog[i]);
            end
        end
        checks++; if (done_at !== 33) begin errors++; $display("FAIL replay_done_at got=%0d want=33", done_at); end
    endtask

    task automatic test_debounce_loop();
        int dones;
        start(1'b0);
        watch(50, 0, -1, 1'b0, 1'b0);
        @(negedge clk); db_clr = 1'b1;
        @(negedge clk); db_clr = 1'b0;
        dones = 0;
        for (int p = 0; p < 4; p++) begin
            start(1'b1);
            watch(50, 0, -1, 1'b0, 1'b0);
            dones += done_cnt;
            start(1'b0);
            watch(50, 0, -1, 1'b0, 1'b0);
            dones += done_cnt;
        end
        checks++; if (dones !== 8) begin errors++; $display("FAIL loop_dones got=%0d want=8", dones); end
        checks++; if (leds !== 8'd4) begin errors++; $display("FAIL loop_leds got=%0d want=4", leds); end
    endtask

    initial begin
        test_reset();
        test_press_bounce();
        test_same_level();
        test_ignore_start();
        test_reset_mid_burst();
        test_debounce_loop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
